// File: rtl/taus_urng_multi.sv
// taus_urng_multi: NUM_CH lockstep taus88 generators with valid/ready output, checked seed reload and draw counter
module taus_urng_multi #(
    parameter int NUM_CH = 4,
    parameter int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [32*NUM_CH-1:0]  out_data,
    input  logic                  seed_we,
    input  logic [CH_W-1:0]       seed_ch,
    input  logic [1:0]            seed_comp,
    input  logic [31:0]           seed_data,
    output logic                  seed_err,
    output logic [31:0]           sample_cnt
);
    logic [31:0] s0 [NUM_CH];
    logic [31:0] s1 [NUM_CH];
    logic [31:0] s2 [NUM_CH];
    logic        fire, accept;
    logic [31:0] seed_min;

    function automatic logic [31:0] taus0(input logic [31:0] x);
        return ((x & 32'hFFFFFFFE) << 12) ^ (((x << 13) ^ x) >> 19);
    endfunction
    function automatic logic [31:0] taus1(input logic [31:0] x);
        return ((x & 32'hFFFFFFF8) << 4) ^ (((x << 2) ^ x) >> 25);
    endfunction
    function automatic logic [31:0] taus2(input logic [31:0] x);
        return ((x & 32'hFFFFFFF0) << 17) ^ (((x << 3) ^ x) >> 11);
    endfunction

    assign fire     = out_valid & out_ready;
    assign seed_min = (seed_comp == 2'd0) ? 32'd2 : (seed_comp == 2'd1) ? 32'd8 : 32'd16;
    assign accept   = seed_we && (32'(seed_ch) < 32'(NUM_CH)) && (seed_comp != 2'd3) && (seed_data >= seed_min);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                s0[c] <= 32'hAA0AA0AA ^ (32'(c) << 24);
                s1[c] <= 32'hB00B00BB ^ (32'(c) << 24);
                s2[c] <= 32'hD00B00DD ^ (32'(c) << 24);
            end
            out_valid  <= 1'b0;
            seed_err   <= 1'b0;
            sample_cnt <= '0;
        end else begin
            // an accepted seed write wins over the recurrence for its one register
            for (int c = 0; c < NUM_CH; c++) begin
                if (accept && seed_ch == CH_W'(c) && seed_comp == 2'd0) s0[c] <= seed_data;
                else if (fire) s0[c] <= taus0(s0[c]);
                if (accept && seed_ch == CH_W'(c) && seed_comp == 2'd1) s1[c] <= seed_data;
                else if (fire) s1[c] <= taus1(s1[c]);
                if (accept && seed_ch == CH_W'(c) && seed_comp == 2'd2) s2[c] <= seed_data;
                else if (fire) s2[c] <= taus2(s2[c]);
            end
            out_valid  <= en & ~seed_we;
            seed_err   <= seed_we & ~accept;
            sample_cnt <= sample_cnt + 32'(fire);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign out_data[32*g +: 32] = s0[g] ^ s1[g] ^ s2[g];
    end
endmodule

// File: tb/tb_taus_urng_multi.sv
// tb_taus_urng_multi: checks taus_urng_multi (3 channels) against a taus88 reference model
module tb_taus_urng_multi;
    localparam int NC = 3;

    logic            clock = 0, reset_n = 0, en = 0, out_ready = 0, seed_we = 0;
    logic [1:0]      seed_ch = 0, seed_comp = 0;
    logic [31:0]     seed_data = 0, sample_cnt;
    logic            out_valid, seed_err;
    logic [32*NC-1:0] out_data, snap;

    taus_urng_multi #(.NUM_CH(NC)) dut (
        .clock(clock), .reset_n(reset_n), .en(en), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .seed_we(seed_we),
        .seed_ch(seed_ch), .seed_comp(seed_comp), .seed_data(seed_data),
        .seed_err(seed_err), .sample_cnt(sample_cnt)
    );

    always #5 clock = ~clock;

    int checks = 0, failures = 0;
    logic [31:0] m0 [NC], m1 [NC], m2 [NC];
    logic        mv, merr;
    logic [31:0] mcnt;

    typedef struct {
        logic [1:0]  ch;
        logic [1:0]  comp;
        logic [31:0] data;
        logic        err;
    } wr_t;
    wr_t tbl [7];

    function automatic logic [31:0] t0(input logic [31:0] x);
        return ((x & 32'hFFFFFFFE) << 12) ^ (((x << 13) ^ x) >> 19);
    endfunction
    function automatic logic [31:0] t1(input logic [31:0] x);
        return ((x & 32'hFFFFFFF8) << 4) ^ (((x << 2) ^ x) >> 25);
    endfunction
    function automatic logic [31:0] t2(input logic [31:0] x);
        return ((x & 32'hFFFFFFF0) << 17) ^ (((x << 3) ^ x) >> 11);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic mreset();
        for (int c = 0; c < NC; c++) begin
            m0[c] = 32'hAA0AA0AA ^ (32'(c) << 24);
            m1[c] = 32'hB00B00BB ^ (32'(c) << 24);
            m2[c] = 32'hD00B00DD ^ (32'(c) << 24);
        end
        mv = 0; merr = 0; mcnt = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, " valid"}, 32'(out_valid), 32'(mv));
        chk({tag, " err"}, 32'(seed_err), 32'(merr));
        chk({tag, " cnt"}, sample_cnt, mcnt);
        for (int c = 0; c < NC; c++)
            chk($sformatf("%s ch%0d", tag, c), out_data[32*c +: 32], m0[c] ^ m1[c] ^ m2[c]);
    endtask

    // one clock: drive at negedge, advance model at posedge, compare at next negedge
    task automatic cyc(input logic e, input logic r, input logic we, input logic [1:0] ch,
                       input logic [1:0] comp, input logic [31:0] d, input string tag);
        logic fire, ok;
        logic [31:0] mn;
        en = e; out_ready = r; seed_we = we; seed_ch = ch; seed_comp = comp; seed_data = d;
        @(posedge clock);
        fire = mv & r;
        mn = (comp == 0) ? 2 : (comp == 1) ? 8 : 16;
        ok = we && ch < NC && comp != 3 && d >= mn;
        if (fire)
            for (int c = 0; c < NC; c++) begin
                m0[c] = t0(m0[c]); m1[c] = t1(m1[c]); m2[c] = t2(m2[c]);
            end
        if (ok) begin
            if (comp == 0) m0[ch] = d;
            if (comp == 1) m1[ch] = d;
            if (comp == 2) m2[ch] = d;
        end
        mcnt = mcnt + 32'(fire);
        merr = we & ~ok;
        mv = e & ~we;
        @(negedge clock);
        check_all(tag);
    endtask

    initial begin
        tbl[0] = '{2'd3, 2'd0, 32'h100, 1'b1};
        tbl[1] = '{2'd0, 2'd3, 32'h100, 1'b1};
        tbl[2] = '{2'd0, 2'd0, 32'h1,   1'b1};
        tbl[3] = '{2'd2, 2'd2, 32'hF,   1'b1};
        tbl[4] = '{2'd1, 2'd1, 32'h8,   1'b0};
        tbl[5] = '{2'd0, 2'd2, 32'h10,  1'b0};
        tbl[6] = '{2'd2, 2'd0, 32'h2,   1'b0};
        mreset();
        #12 @(negedge clock);
        chk("reset valid", 32'(out_valid), 32'h0);
        chk("reset ch0", out_data[31:0], 32'hCA0AA0CC);
        chk("reset ch1", out_data[63:32], 32'hCB0AA0CC);
        chk("reset cnt", sample_cnt, 32'h0);
        reset_n = 1;
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0, "idle");
        chk("idle ch0", out_data[31:0], 32'hCA0AA0CC);

        for (int i = 0; i < 2000 && mcnt < 1000; i++) cyc(1, 1, 0, 0, 0, 0, "stream");
        chk("cnt 1000", sample_cnt, 32'd1000);

        snap = out_data;
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0, 0, 0, 0, "stall");
            chk("stall frozen", out_data[31:0] ^ snap[31:0] ^ out_data[95:64] ^ snap[95:64], 32'h0);
        end
        cyc(1, 1, 0, 0, 0, 0, "resume");

        cyc(1, 1, 1, 2, 1, 32'h100, "seed");
        chk("seed drop valid", 32'(out_valid), 32'h0);
        cyc(1, 1, 0, 0, 0, 0, "seed rec");
        chk("seed back valid", 32'(out_valid), 32'h1);
        for (int i = 0; i < 20; i++) cyc(1, 1, 0, 0, 0, 0, "post seed");

        for (int i = 0; i < 7; i++) begin
            cyc(1, 1, 1, tbl[i].ch, tbl[i].comp, tbl[i].data, "table");
            chk($sformatf("table%0d err", i), 32'(seed_err), 32'(tbl[i].err));
        end
        cyc(1, 1, 0, 0, 0, 0, "table idle");
        chk("err cleared", 32'(seed_err), 32'h0);

        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 7) != 0, 1'($urandom), $urandom_range(0, 11) == 0,
                2'($urandom), 2'($urandom), ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 31)) : $urandom,
                "random");

        cyc(1, 1, 0, 0, 0, 0, "prewrap");
        force dut.sample_cnt = 32'hFFFFFFFF;
        #1 release dut.sample_cnt;
        mcnt = 32'hFFFFFFFF;
        cyc(1, 1, 0, 0, 0, 0, "wrap");
        chk("cnt wrap", sample_cnt, 32'h0);

        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 0, 0, "prereset");
        seed_we = 1; seed_ch = 0; seed_comp = 0; seed_data = 32'h1234;
        #2 reset_n = 0;
        #1;
        chk("async valid", 32'(out_valid), 32'h0);
        chk("async err", 32'(seed_err), 32'h0);
        chk("async cnt", sample_cnt, 32'h0);
        chk("async ch0", out_data[31:0], 32'hCA0AA0CC);
        chk("async ch1", out_data[63:32], 32'hCB0AA0CC);
        mreset();
        @(negedge clock);
        reset_n = 1;
        for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0, 0, 0, "after reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
